// File: rtl/fetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_pkg: shared fetch-buffer state encoding and default sizes
// Rev 1.0
// ------------------------------------------------------------------
package fetch_pkg;

  localparam int DEFAULT_W     = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_slot_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_slot_mem: DEPTH x (pc, instr) slot storage, async read
// Rev 1.0
// ------------------------------------------------------------------
module fetch_slot_mem
  import fetch_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_we,
  input  logic [AW-1:0] pc_waddr,
  input  logic [W-1:0]  pc_wdata,
  input  logic          instr_we,
  input  logic [AW-1:0] instr_waddr,
  input  logic [W-1:0]  instr_wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rd_pc,
  output logic [W-1:0]  rd_instr
);

  logic [W-1:0] r_pc_mem    [DEPTH];
  logic [W-1:0] r_instr_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_pc_mem[i] <= '0;
    end else if (pc_we) begin
      r_pc_mem[pc_waddr] <= pc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_instr_mem[i] <= '0;
    end else if (instr_we) begin
      r_instr_mem[instr_waddr] <= instr_wdata;
    end
  end

  assign rd_pc    = r_pc_mem[raddr];
  assign rd_instr = r_instr_mem[raddr];

endmodule : fetch_slot_mem
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_buffer: in-order instruction fetch queue with flush drain
// Rev 1.0
// ------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pc,
  output logic         pc_write,
  input  logic         flush,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [W-1:0] imem_rdata,
  output logic         if_valid,
  output logic [W-1:0] if_pc,
  output logic [W-1:0] if_instr,
  input  logic         id_ready,
  output logic         proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] c_depth = PW'(DEPTH);
  localparam logic [PW-1:0] c_one   = PW'(1);

  logic [PW-1:0] r_alloc, r_fill, r_rd, r_discard_cnt;
  logic [PW-1:0] w_alloc_nxt, w_fill_nxt, w_rd_nxt, w_discard_nxt;
  logic [PW-1:0] w_inflight, w_occ, w_avail;
  fetch_state_e  r_state, w_state_nxt;
  logic          r_proto_err, w_proto_nxt;
  logic          w_fill, w_pop, w_stray;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alloc       <= '0;
      r_fill        <= '0;
      r_rd          <= '0;
      r_discard_cnt <= '0;
      r_state       <= RUN;
      r_proto_err   <= 1'b0;
    end else begin
      r_alloc       <= w_alloc_nxt;
      r_fill        <= w_fill_nxt;
      r_rd          <= w_rd_nxt;
      r_discard_cnt <= w_discard_nxt;
      r_state       <= w_state_nxt;
      r_proto_err   <= w_proto_nxt;
    end
  end

  // Credits come only from registered pointers, so a pop never frees a slot for the same-cycle issue.
  always_comb begin
    w_inflight    = r_alloc - r_fill;
    w_occ         = r_alloc - r_rd;
    w_avail       = r_fill - r_rd;
    imem_req      = rst && (r_state == RUN) && (w_occ < c_depth) && !flush;
    pc_write      = imem_req && imem_gnt;
    if_valid      = rst && (w_avail != '0) && !flush;
    w_pop         = if_valid && id_ready;
    w_fill        = (r_state == RUN) && imem_rvalid && (w_inflight != '0);
    w_stray       = (r_state == RUN) && imem_rvalid && (w_inflight == '0);
    w_alloc_nxt   = r_alloc;
    w_fill_nxt    = r_fill;
    w_rd_nxt      = r_rd;
    w_discard_nxt = r_discard_cnt;
    w_proto_nxt   = r_proto_err || w_stray;
    if (flush) begin
      w_alloc_nxt = '0;
      w_fill_nxt  = '0;
      w_rd_nxt    = '0;
      if (r_state == RUN) begin
        w_discard_nxt = w_fill ? (w_inflight - c_one) : w_inflight;
      end else if (imem_rvalid) begin
        w_discard_nxt = r_discard_cnt - c_one;
      end
    end else if (r_state == DRAIN) begin
      if (imem_rvalid) w_discard_nxt = r_discard_cnt - c_one;
    end else begin
      if (pc_write) w_alloc_nxt = r_alloc + c_one;
      if (w_fill)   w_fill_nxt  = r_fill + c_one;
      if (w_pop)    w_rd_nxt    = r_rd + c_one;
    end
    w_state_nxt = (w_discard_nxt != '0) ? DRAIN : RUN;
  end

  assign imem_addr = pc;
  assign proto_err = r_proto_err;

  fetch_slot_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_slot_mem (
    .clk         (clk),
    .rst         (rst),
    .pc_we       (pc_write),
    .pc_waddr    (r_alloc[AW-1:0]),
    .pc_wdata    (pc),
    .instr_we    (w_fill && !flush),
    .instr_waddr (r_fill[AW-1:0]),
    .instr_wdata (imem_rdata),
    .raddr       (r_rd[AW-1:0]),
    .rd_pc       (if_pc),
    .rd_instr    (if_instr)
  );

endmodule : fetch_buffer
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_buffer: directed + randomized bench with queue-based model
// Rev 1.0
// ------------------------------------------------------------------
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc;
  logic         pc_write;
  logic         flush;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instr;
  logic         id_ready;
  logic         proto_err;

  always #5 clk = ~clk;

  fetch_buffer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_write(pc_write), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready), .proto_err(proto_err)
  );

  // Model: requests granted but not yet answered (dropped = killed by a flush),
  // and completed entries waiting for decode.
  typedef struct { logic [W-1:0] pc; bit dropped; } req_t;
  typedef struct { logic [W-1:0] pc; logic [W-1:0] instr; } ent_t;
  req_t out_q[$];
  ent_t rdy_q[$];
  bit   exp_proto;
  bit   exp_req, exp_pcw, exp_ifv;
  logic [W-1:0] exp_ifpc, exp_ifinstr;
  int   checks = 0;
  int   passed = 0;

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic void compute_exp();
    int live = rdy_q.size();
    bit draining = 1'b0;
    foreach (out_q[i]) begin
      if (out_q[i].dropped) draining = 1'b1;
      else live++;
    end
    exp_req     = !draining && (live < DEPTH) && !flush;
    exp_pcw     = exp_req && imem_gnt;
    exp_ifv     = (rdy_q.size() > 0) && !flush;
    exp_ifpc    = exp_ifv ? rdy_q[0].pc : '0;
    exp_ifinstr = exp_ifv ? rdy_q[0].instr : '0;
  endfunction

  task automatic apply(input bit f, input bit g, input bit rv, input bit rdy, input logic [W-1:0] p);
    flush       = f;
    imem_gnt    = g;
    imem_rvalid = rv;
    id_ready    = rdy;
    pc          = p;
    imem_rdata  = (rv && out_q.size() > 0) ? instr_of(out_q[0].pc) : W'($urandom);
    #1;
    compute_exp();
  endtask

  task automatic tick();
    compute_exp();
    if (flush) begin
      if (imem_rvalid && out_q.size() > 0) void'(out_q.pop_front());
      else if (imem_rvalid) exp_proto = 1'b1;
      foreach (out_q[i]) out_q[i].dropped = 1'b1;
      rdy_q.delete();
    end else begin
      if (exp_ifv && id_ready) void'(rdy_q.pop_front());
      if (imem_rvalid) begin
        if (out_q.size() == 0) begin
          exp_proto = 1'b1;
        end else begin
          req_t h;
          h = out_q.pop_front();
          if (!h.dropped) rdy_q.push_back('{h.pc, imem_rdata});
        end
      end
      if (exp_pcw) out_q.push_back('{pc, 1'b0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
    pc = '0; imem_rdata = '0;
    out_q.delete();
    rdy_q.delete();
    exp_proto = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; id_ready = 1'b1; pc = 32'h40;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %b want 0", imem_req); else passed++;
    checks++; if (pc_write !== 1'b0) $display("FAIL reset_pc_write: got %b want 0", pc_write); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", if_valid); else passed++;
    checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", proto_err); else passed++;
    do_reset();
    apply(0, 1, 0, 1, 32'h40);
    checks++; if (imem_req !== 1'b1) $display("FAIL idle_imem_req: got %b want 1", imem_req); else passed++;
    checks++; if (imem_addr !== 32'h40) $display("FAIL idle_imem_addr: got %h want 00000040", imem_addr); else passed++;
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(0, 1, i > 0, 1, 32'(4 * i));
      checks++; if (pc_write !== 1'b1) $display("FAIL stream_pc_write[%0d]: got %b want 1", i, pc_write); else passed++;
      if (i >= 2) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 2)) || if_instr !== instr_of(32'(4 * (i - 2))))
          $display("FAIL stream_head[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                   i, if_valid, if_pc, if_instr, 32'(4 * (i - 2)), instr_of(32'(4 * (i - 2))));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(0, 1, out_q.size() > 0, 0, 32'(16 * i));
      if (pc_write === 1'b1) grants++;
      tick();
    end
    checks++; if (grants != DEPTH) $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH); else passed++;
    apply(0, 1, 0, 0, 32'h200);
    checks++; if (imem_req !== 1'b0) $display("FAIL bp_full_req: got %b want 0", imem_req); else passed++;
    tick();
    apply(0, 1, 0, 1, 32'h200);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); else passed++;
    checks++; if (pc_write !== 1'b0) $display("FAIL bp_pop_no_credit: got %b want 0", pc_write); else passed++;
    tick();
    apply(0, 1, 0, 1, 32'h200);
    checks++; if (pc_write !== 1'b1) $display("FAIL bp_after_pop: got %b want 1", pc_write); else passed++;
    tick();
  endtask

  task automatic test_flush_drain();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 1, 32'(100 + 4 * i));
      tick();
    end
    apply(1, 1, 0, 1, 32'h300);
    checks++; if (imem_req !== 1'b0 || pc_write !== 1'b0) $display("FAIL flush_req: got req=%b pcw=%b want 0 0", imem_req, pc_write); else passed++;
    tick();
    checks++; if (dut.r_state !== DRAIN) $display("FAIL drain_state: got %0d want %0d", dut.r_state, DRAIN); else passed++;
    checks++; if (dut.r_discard_cnt !== 3) $display("FAIL drain_cnt: got %0d want 3", dut.r_discard_cnt); else passed++;
    for (int j = 0; j < 3; j++) begin
      apply(0, 1, 1, 1, 32'h300);
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL drain_drop[%0d]: got v=%b req=%b want 0 0", j, if_valid, imem_req); else passed++;
      tick();
    end
    apply(0, 1, 0, 1, 32'h300);
    checks++; if (imem_req !== 1'b1 || dut.r_state !== RUN) $display("FAIL drain_exit: got req=%b state=%0d want 1 RUN", imem_req, dut.r_state); else passed++;
    tick();
  endtask

  task automatic test_flush_rvalid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 32'(200 + 4 * i));
      tick();
    end
    apply(0, 0, 1, 0, 32'h0);
    tick();
    apply(1, 0, 1, 1, 32'h0);
    checks++; if (if_valid !== 1'b0) $display("FAIL flush_rv_if_valid: got %b want 0", if_valid); else passed++;
    tick();
    checks++; if (dut.r_discard_cnt !== 1 || dut.r_state !== DRAIN) $display("FAIL flush_rv_cnt: got cnt=%0d state=%0d want 1 DRAIN", dut.r_discard_cnt, dut.r_state); else passed++;
    apply(0, 0, 1, 1, 32'h0);
    checks++; if (imem_req !== 1'b0) $display("FAIL flush_rv_drain_req: got %b want 0", imem_req); else passed++;
    tick();
    apply(0, 1, 0, 1, 32'h0);
    checks++; if (imem_req !== 1'b1) $display("FAIL flush_rv_exit: got %b want 1", imem_req); else passed++;
    tick();
  endtask

  task automatic test_full_fill_pop();
    logic [$clog2(DEPTH):0] occ;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, out_q.size() > 0, 0, 32'(32'h400 + 8 * i));
      tick();
    end
    apply(0, 1, 1, 1, 32'h500);
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1) $display("FAIL full_both: got req=%b v=%b want 0 1", imem_req, if_valid); else passed++;
    tick();
    occ = dut.r_fill - dut.r_rd;
    checks++; if (occ !== 3) $display("FAIL full_occupancy: got %0d want 3", occ); else passed++;
    apply(0, 0, 0, 0, 32'h500);
    checks++; if (if_pc !== 32'h408 || if_instr !== instr_of(32'h408)) $display("FAIL full_next_head: got pc=%h instr=%h want 00000408 %h", if_pc, if_instr, instr_of(32'h408)); else passed++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            out_q.size() > 0 && $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, W'($urandom));
      checks++; if (imem_req !== exp_req) $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, exp_req); else passed++;
      checks++; if (pc_write !== exp_pcw) $display("FAIL rnd_pc_write[%0d]: got %b want %b", i, pc_write, exp_pcw); else passed++;
      checks++; if (if_valid !== exp_ifv) $display("FAIL rnd_if_valid[%0d]: got %b want %b", i, if_valid, exp_ifv); else passed++;
      checks++; if (imem_addr !== pc) $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, pc); else passed++;
      checks++; if (proto_err !== exp_proto) $display("FAIL rnd_proto[%0d]: got %b want %b", i, proto_err, exp_proto); else passed++;
      if (exp_ifv) begin
        checks++;
        if (if_pc !== exp_ifpc || if_instr !== exp_ifinstr)
          $display("FAIL rnd_head[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, if_pc, if_instr, exp_ifpc, exp_ifinstr);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_stray_rvalid();
    do_reset();
    apply(0, 0, 1, 0, 32'h0);
    checks++; if (proto_err !== 1'b0) $display("FAIL stray_before: got %b want 0", proto_err); else passed++;
    tick();
    checks++; if (proto_err !== 1'b1) $display("FAIL stray_set: got %b want 1", proto_err); else passed++;
    checks++; if (dut.r_alloc !== 0 || dut.r_fill !== 0 || dut.r_rd !== 0 || if_valid !== 1'b0)
      $display("FAIL stray_ptrs: got alloc=%0d fill=%0d rd=%0d v=%b want 0 0 0 0", dut.r_alloc, dut.r_fill, dut.r_rd, if_valid);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, out_q.size() > 0, 1, 32'(8 * i));
      tick();
    end
    checks++; if (proto_err !== 1'b1) $display("FAIL stray_sticky: got %b want 1", proto_err); else passed++;
  endtask

  task automatic test_async_reset();
    apply(0, 1, out_q.size() > 0, 1, 32'h600);
    checks++; if (pc_write !== 1'b1) $display("FAIL areset_pre_pcw: got %b want 1", pc_write); else passed++;
    #1;
    rst = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_write !== 1'b0 || proto_err !== 1'b0)
      $display("FAIL areset_outputs: got v=%b req=%b pcw=%b perr=%b want 0 0 0 0", if_valid, imem_req, pc_write, proto_err);
    else passed++;
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
    pc = '0; imem_rdata = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_drain();
    test_flush_rvalid();
    test_full_fill_pop();
    test_random();
    test_stray_rvalid();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_fetch_buffer
`default_nettype wire
